// File: rtl/mips_mc_ctrl_fsm.sv
// mips_mc_ctrl_fsm
// Main control state machine of the multicycle MIPS datapath. Each
// instruction is sequenced through fetch, decode, execute, memory and
// writeback. Every datapath enable and mux select is decoded from the state
// register, plus the 2-bit aluOp for the ALU-control decoder.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   opcode[5:0]     IR[31:26], valid from Decode onward
//   memReady        memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], aluOp[1:0], PCSource[1:0]
//                   datapath controls
//   instrDone       high in the last cycle of each instruction
//   illegalOp       sticky flag: an unsupported opcode was decoded
//   dbgState        current state encoding
module mips_mc_ctrl_fsm #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               memReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         aluOp,
  output logic [1:0]         PCSource,
  output logic               instrDone,
  output logic               illegalOp,
  output logic [STATE_W-1:0] dbgState
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADDR = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_EXEC    = STATE_W'(6),
    S_RWB     = STATE_W'(7),
    S_BRANCH  = STATE_W'(8),
    S_JUMP    = STATE_W'(9),
    S_ADDIEX  = STATE_W'(10),
    S_ADDIWB  = STATE_W'(11)
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e state_r;
  logic   illegal_r;
  logic   ready_s;

  // With single-cycle memory every access completes immediately.
  assign ready_s   = memReady | ~USE_MEM_READY;
  assign dbgState  = state_r;
  assign illegalOp = illegal_r;

  // State register and sticky illegal-opcode flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_FETCH;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (ready_s) state_r <= S_DECODE;
          else         state_r <= S_FETCH;
        end
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_r <= S_MEMADDR;
            OP_RTYPE:     state_r <= S_EXEC;
            OP_BEQ:       state_r <= S_BRANCH;
            OP_J:         state_r <= S_JUMP;
            OP_ADDI:      state_r <= S_ADDIEX;
            default: begin
              state_r   <= S_FETCH;
              illegal_r <= 1'b1;
            end
          endcase
        end
        // IR still holds the instruction, so lw/sw is re-resolved here.
        S_MEMADDR: begin
          if (opcode == OP_SW) state_r <= S_MEMWR;
          else                 state_r <= S_MEMRD;
        end
        S_MEMRD: begin
          if (ready_s) state_r <= S_MEMWB;
          else         state_r <= S_MEMRD;
        end
        S_MEMWR: begin
          if (ready_s) state_r <= S_FETCH;
          else         state_r <= S_MEMWR;
        end
        S_EXEC:   state_r <= S_RWB;
        S_ADDIEX: state_r <= S_ADDIWB;
        S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_r <= S_FETCH;
        default:  state_r <= S_FETCH;
      endcase
    end
  end

  // Output decode from state; memReady only gates the completing strobes,
  // and reset masks every write enable without waiting for a clock edge.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    aluOp       = 2'b00;
    PCSource    = 2'b00;
    instrDone   = 1'b0;
    case (state_r)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = ready_s;
        PCWrite = ready_s;
        ALUSrcB = 2'b01;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        instrDone = 1'b1;
      end
      S_MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        instrDone = ready_s;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        aluOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        instrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        aluOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instrDone   = 1'b1;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        instrDone = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        instrDone = 1'b1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      instrDone   = 1'b0;
    end else begin
      instrDone = instrDone;
    end
  end

endmodule
